// File: rtl/sort_group_serializer.sv
// sort_group_serializer
//   Captures sorted 4-element groups from the non-stallable sort unit into a
//   small group FIFO and streams each group out one element per cycle,
//   smallest element first, on a val/rdy interface.
//   A group that arrives while the FIFO is full is dropped, unless the head
//   group's last element leaves in the same cycle. A dropped group sets the
//   sticky overflow flag.
//   Optional build macro SORT_GROUP_SERIALIZER_CHECK_EN adds an ordering check
//   on every enqueued group. The check drives the sticky unsorted flag. When
//   the macro is undefined, unsorted is tied low.
module sort_group_serializer #(
  parameter int p_nbits = 8,
  parameter int p_depth = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_val,
  input  logic [p_nbits-1:0]           in0,
  input  logic [p_nbits-1:0]           in1,
  input  logic [p_nbits-1:0]           in2,
  input  logic [p_nbits-1:0]           in3,
  output logic                         ostream_val,
  input  logic                         ostream_rdy,
  output logic [p_nbits-1:0]           ostream_msg,
  output logic                         ostream_last,
  output logic [$clog2(p_depth+1)-1:0] count,
  output logic                         full,
  output logic                         overflow,
  output logic                         unsorted
);

  localparam int CW = $clog2(p_depth + 1);
  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(p_depth);
  localparam logic [PW-1:0] LAST_PTR = PW'(p_depth - 1);

  // Group storage plus FIFO bookkeeping
  logic [p_nbits-1:0] mem_r [0:p_depth-1][0:3];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [1:0]         idx_r;
  logic [CW-1:0]      count_r;
  logic               overflow_r;

  logic               nonempty_s;
  logic               full_s;
  logic               xfer_s;
  logic               pop_s;
  logic               enq_s;
  logic               drop_s;

  logic [PW-1:0]      wr_ptr_nxt_s;
  logic [PW-1:0]      rd_ptr_nxt_s;
  logic [1:0]         idx_nxt_s;
  logic [CW-1:0]      count_nxt_s;
  logic               overflow_nxt_s;

  // Pointers wrap explicitly so that non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1'b1);
    end
  endfunction

  // Handshake decode. A final-element pop frees the head slot, so a full FIFO
  // can still accept a new group in that cycle.
  always_comb begin
    nonempty_s = (count_r != {CW{1'b0}});
    full_s     = (count_r == FULL_CNT);
    xfer_s     = nonempty_s & ostream_rdy;
    pop_s      = xfer_s & (idx_r == 2'd3);
    enq_s      = in_val & (~full_s | pop_s);
    drop_s     = in_val & full_s & ~pop_s;
  end

  // Next-state computation for pointers, element index, occupancy and overflow
  always_comb begin
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    idx_nxt_s      = idx_r;
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r | drop_s;

    if (enq_s) begin
      wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      idx_nxt_s    = 2'd0;
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else if (xfer_s) begin
      idx_nxt_s    = idx_r + 2'd1;
      rd_ptr_nxt_s = rd_ptr_r;
    end else begin
      idx_nxt_s    = idx_r;
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({enq_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state register. The reset also discards a group that is mid-stream.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      idx_r      <= 2'd0;
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      idx_r      <= idx_nxt_s;
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  // Group payload write. Data is not reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (reset && enq_s) begin
      mem_r[wr_ptr_r][0] <= in0;
      mem_r[wr_ptr_r][1] <= in1;
      mem_r[wr_ptr_r][2] <= in2;
      mem_r[wr_ptr_r][3] <= in3;
    end
  end

  // Output view. It is driven only from registers, with zeros while empty.
  always_comb begin
    ostream_val = nonempty_s;
    if (nonempty_s) begin
      ostream_msg  = mem_r[rd_ptr_r][idx_r];
      ostream_last = (idx_r == 2'd3);
    end else begin
      ostream_msg  = {p_nbits{1'b0}};
      ostream_last = 1'b0;
    end
  end

  assign count    = count_r;
  assign full     = full_s;
  assign overflow = overflow_r;

`ifdef SORT_GROUP_SERIALIZER_CHECK_EN
  logic unsorted_r;

  // Unsigned non-decreasing order test across one group
  function automatic logic in_order(input logic [p_nbits-1:0] a,
                                    input logic [p_nbits-1:0] b,
                                    input logic [p_nbits-1:0] c,
                                    input logic [p_nbits-1:0] d);
    return (a <= b) && (b <= c) && (c <= d);
  endfunction

  // Sticky order error. Only accepted groups are checked; dropped groups are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      unsorted_r <= 1'b0;
    end else if (enq_s && !in_order(in0, in1, in2, in3)) begin
      unsorted_r <= 1'b1;
    end else begin
      unsorted_r <= unsorted_r;
    end
  end

  assign unsorted = unsorted_r;
`else
  assign unsorted = 1'b0;
`endif

endmodule

// File: tb/tb_sort_group_serializer.sv
// tb_sort_group_serializer
//   Self-checking bench for sort_group_serializer.
//   The reference model is a plain element queue.
//   - Occupancy is ceil(elements/4).
//   - The head element is the front of the queue.
//   - The last flag is set when one element of the head group remains.
module tb_sort_group_serializer;

  localparam int DEPTH = 2;

  logic       clk;
  logic       reset;
  logic       in_val;
  logic [7:0] in0, in1, in2, in3;
  logic       ostream_val;
  logic       ostream_rdy;
  logic [7:0] ostream_msg;
  logic       ostream_last;
  logic [1:0] count;
  logic       full;
  logic       overflow;
  logic       unsorted;

  int n_checks;
  int n_errors;

  byte unsigned q[$];
  bit m_ovf;
  bit m_uns;

  sort_group_serializer #(.p_nbits(8), .p_depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_val(in_val),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
    .ostream_msg(ostream_msg), .ostream_last(ostream_last),
    .count(count), .full(full), .overflow(overflow), .unsorted(unsorted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int n;
    n = q.size();
    check_eq("val",   32'(ostream_val),  32'(n != 0));
    check_eq("msg",   32'(ostream_msg),  (n != 0) ? 32'(q[0]) : 32'd0);
    check_eq("last",  32'(ostream_last), 32'((n != 0) && (n % 4 == 1)));
    check_eq("count", 32'(count),        32'((n + 3) / 4));
    check_eq("full",  32'(full),         32'(((n + 3) / 4) == DEPTH));
    check_eq("overflow", 32'(overflow),  32'(m_ovf));
`ifdef SORT_GROUP_SERIALIZER_CHECK_EN
    check_eq("unsorted", 32'(unsorted),  32'(m_uns));
`else
    check_eq("unsorted", 32'(unsorted),  32'd0);
`endif
  endtask

  // One clock cycle with given inputs; model advances at the same edge
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d, input logic r);
    int  n;
    bit  fl, xf, pop;
    in_val = v; in0 = a; in1 = b; in2 = c; in3 = d; ostream_rdy = r;
    n   = q.size();
    fl  = ((n + 3) / 4) == DEPTH;
    xf  = (n != 0) && r;
    pop = xf && (n % 4 == 1);
    @(posedge clk);
    if (xf) void'(q.pop_front());
    if (v) begin
      if (!fl || pop) begin
        q.push_back(a); q.push_back(b); q.push_back(c); q.push_back(d);
        if (!((a <= b) && (b <= c) && (c <= d))) m_uns = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1;
    compare_outputs();
  endtask

  task automatic idle(input logic r);
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, r);
  endtask

  task automatic do_reset();
    reset = 1'b0; in_val = 1'b0; ostream_rdy = 1'b1;
    @(posedge clk);
    q.delete(); m_ovf = 1'b0; m_uns = 1'b0;
    #1;
    reset = 1'b1;
    compare_outputs();
  endtask

  initial begin
    logic [7:0] v[4];
    logic [7:0] t;
    n_checks = 0; n_errors = 0;
    reset = 1'b0; in_val = 1'b0; ostream_rdy = 1'b1;
    in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
    @(posedge clk); #1;
    do_reset();

    // 1: idle after reset
    for (int i = 0; i < 3; i++) idle(1'b1);

    // 2: single group streamed ascending
    step(1'b1, 8'h01, 8'h03, 8'h05, 8'h07, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // 3: fill, drop third group, then drain
    step(1'b1, 8'h10, 8'h11, 8'h12, 8'h13, 1'b0);
    step(1'b1, 8'h20, 8'h21, 8'h22, 8'h23, 1'b0);
    step(1'b1, 8'h30, 8'h31, 8'h32, 8'h33, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // 4: enqueue into full FIFO on the cycle the head's last element leaves
    do_reset();
    step(1'b1, 8'h10, 8'h11, 8'h12, 8'h13, 1'b0);
    step(1'b1, 8'h20, 8'h21, 8'h22, 8'h23, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    step(1'b1, 8'h40, 8'h41, 8'h42, 8'h43, 1'b1);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // 5: stalled consumer, rdy pattern 1,0,0,1,...
    step(1'b1, 8'h05, 8'h06, 8'h07, 8'h08, 1'b1);
    for (int i = 0; i < 14; i++) idle((i % 3) == 2);
    idle(1'b1);

    // 6: reset mid-stream, then restart; unsorted group still streamed
    step(1'b1, 8'h50, 8'h51, 8'h52, 8'h53, 1'b1);
    idle(1'b1);
    idle(1'b1);
    do_reset();
    step(1'b1, 8'haa, 8'hbb, 8'hcc, 8'hdd, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    step(1'b1, 8'h09, 8'h02, 8'h03, 8'h04, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 4; k++) v[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 8) begin
        for (int p = 0; p < 3; p++)
          for (int k = 0; k < 3 - p; k++)
            if (v[k] > v[k+1]) begin t = v[k]; v[k] = v[k+1]; v[k+1] = t; end
      end
      if (cyc == 1500) do_reset();
      step($urandom_range(0, 4) == 0, v[0], v[1], v[2], v[3],
           $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
